// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and fill-engine state type.
//   FB_WIDTH x FB_HEIGHT RGB 8:8:8 framebuffer, FB_WORDS valid words.
//   fill_state_t : fill engine FSM states.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 280;
  localparam int unsigned FB_HEIGHT = 192;
  localparam int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_DATA_W = 24;
  localparam int unsigned FB_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req_i   : per-slot request vector
//   ptr_i   : last winning slot; search starts at ptr_i+1 (mod N)
//   gnt_o   : one-hot grant (or zero)
//   idx_o   : index of the granted slot
//   valid_o : a grant was issued
module fb_rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    logic [31:0]     slot;
    logic [IdxW-1:0] slot_idx;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      slot = 32'(ptr_i) + k;
      if (slot >= N) slot = slot - N;
      slot_idx = IdxW'(slot);
      if (!valid_o && req_i[slot_idx]) begin
        gnt_o[slot_idx] = 1'b1;
        idx_o           = slot_idx;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer RAM write-port owner: round-robin between NUM_REQ external
// pixel writers and a built-in fill engine, one registered write per cycle.
//   CLOCK_50 / reset          : clock, async active-low reset
//   req_valid/ready/adr/data  : external writers (flattened vectors)
//   fill_start/abort/base/count/color, fill_busy/done : fill engine
//   fb_d / fb_adr_w / fb_we   : RAM write port (registered)
//   oob_err / oob_clr         : sticky out-of-bounds flag
// Optional feature macro: FB_WR_BOUNDS_CHECK_EN (drop writes at addr >= FB_WORDS).
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DATA_W   = fb_pkg::FB_DATA_W,
  parameter int unsigned ADDR_W   = fb_pkg::FB_ADDR_W,
  parameter int unsigned FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fill_start,
  input  logic                      fill_abort,
  input  logic [ADDR_W-1:0]         fill_base,
  input  logic [ADDR_W:0]           fill_count,
  input  logic [DATA_W-1:0]         fill_color,
  output logic                      fill_busy,
  output logic                      fill_done,
  output logic [DATA_W-1:0]         fb_d,
  output logic [ADDR_W-1:0]         fb_adr_w,
  output logic                      fb_we,
  output logic                      oob_err,
  input  logic                      oob_clr
);

  localparam int unsigned NumSlots = NUM_REQ + 1;
  localparam int unsigned IdxW     = $clog2(NumSlots);
  localparam int unsigned FillSlot = NUM_REQ;

  fill_state_t         state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d, idx_q, idx_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic                we_q, we_d, busy_q, busy_d, done_q, done_d, oob_q, oob_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic [NumSlots-1:0] slot_req, gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_valid, fill_gnt, oob_hit;
  logic [ADDR_W-1:0]   sel_adr;
  logic [DATA_W-1:0]   sel_d;

  assign slot_req = {state_q == FILL, req_valid};

  fb_rr_arbiter #(
    .N    (NumSlots),
    .IdxW (IdxW)
  ) u_arb (
    .req_i   (slot_req),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign req_ready = gnt[NUM_REQ-1:0];
  assign fill_gnt  = gnt[FillSlot];

  // Write source mux; fill address wraps modulo 2^ADDR_W by truncation.
  always_comb begin
    sel_adr = base_q + idx_q[ADDR_W-1:0];
    sel_d   = color_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_adr = req_adr[i*ADDR_W +: ADDR_W];
        sel_d   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign oob_hit = gnt_valid && (32'(sel_adr) >= FB_WORDS);

  // Fill engine next state
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    color_d = color_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          base_d  = fill_base;
          count_d = fill_count;
          color_d = fill_color;
          idx_d   = '0;
          state_d = (fill_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        // A grant in the abort cycle is already committed to the output regs.
        if (fill_abort) begin
          state_d = IDLE;
        end else if (fill_gnt) begin
          if (idx_q == count_q - (ADDR_W+1)'(1)) state_d = DONE;
          else                                   idx_d   = idx_q + (ADDR_W+1)'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = gnt_valid ? gnt_idx : ptr_q;
    adr_d  = gnt_valid ? sel_adr : adr_q;
    dat_d  = gnt_valid ? sel_d : dat_q;
    busy_d = (state_d == FILL);
    done_d = (state_q == DONE);
`ifdef FB_WR_BOUNDS_CHECK_EN
    // Out-of-range writes are consumed but never reach the RAM.
    we_d  = gnt_valid && !oob_hit;
    oob_d = oob_hit ? 1'b1 : (oob_clr ? 1'b0 : oob_q);
`else
    we_d  = gnt_valid;
    oob_d = 1'b0;
`endif
  end

`ifndef FB_WR_BOUNDS_CHECK_EN
  logic unused_oob;
  assign unused_oob = oob_hit ^ oob_clr;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      color_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IdxW'(NUM_REQ);
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      color_q <= color_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
    end
  end

  assign fb_we     = we_q;
  assign fb_adr_w  = adr_q;
  assign fb_d      = dat_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign oob_err   = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_fb_write_arbiter;

  localparam int NR    = 2;
  localparam int DW    = 24;
  localparam int AW    = 16;
  localparam int S     = NR + 1;
  localparam int WORDS = 53760;
`ifdef FB_WR_BOUNDS_CHECK_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_adr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              fill_start = 1'b0, fill_abort = 1'b0, oob_clr = 1'b0;
  logic [AW-1:0]     fill_base = '0;
  logic [AW:0]       fill_count = '0;
  logic [DW-1:0]     fill_color = '0;
  logic              fill_busy, fill_done, fb_we, oob_err;
  logic [DW-1:0]     fb_d;
  logic [AW-1:0]     fb_adr_w;

  fb_write_arbiter dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fb_d       (fb_d),
    .fb_adr_w   (fb_adr_w),
    .fb_we      (fb_we),
    .oob_err    (oob_err),
    .oob_clr    (oob_clr)
  );

  always #10 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int wr_count = 0, done_count = 0;
  int refill_pct = 0, adr_lo = 0, adr_span = 0;
  logic [DW-1:0] dut_mem [int];

  // Reference model state (mode: 0 idle, 1 filling, 2 done)
  int m_last, m_mode, m_base, m_count, m_idx, m_fill_wr;
  logic [DW-1:0] m_color, m_d;
  logic [AW-1:0] m_adr;
  bit m_we, m_done, m_oob;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input int a);
    if (dut_mem.exists(a)) return dut_mem[a];
    return 'x;
  endfunction

  task automatic model_reset();
    m_last = NR; m_mode = 0; m_base = 0; m_count = 0; m_idx = 0; m_fill_wr = 0;
    m_color = '0; m_d = '0; m_adr = '0; m_we = 0; m_done = 0; m_oob = 0;
  endtask

  task automatic refill();
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] && refill_pct > 0 && int'($urandom_range(99)) < refill_pct) begin
        req_valid[i]          = 1'b1;
        req_adr[i*AW +: AW]   = AW'(adr_lo + int'($urandom_range(adr_span)));
        req_data[i*DW +: DW]  = DW'($urandom);
      end
    end
  endtask

  // One clock cycle: check DUT at the falling edge, advance the model,
  // then retire accepted requests just after the rising edge.
  task automatic step();
    int win;
    bit hit;
    logic [NR-1:0] exp_ready;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    win = -1;
    for (int k = 1; k <= S; k++) begin
      int s;
      s = (m_last + k) % S;
      if (win < 0 && ((s < NR) ? req_valid[s] == 1'b1 : m_mode == 1)) win = s;
    end
    exp_ready = '0;
    if (win >= 0 && win < NR) exp_ready[win] = 1'b1;
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("fb_we", fb_we, m_we);
    if (m_we) begin
      check_eq("fb_adr_w", fb_adr_w, m_adr);
      check_eq("fb_d", fb_d, m_d);
    end
    check_eq("fill_busy", fill_busy, m_mode == 1);
    check_eq("fill_done", fill_done, m_done);
    check_eq("oob_err", oob_err, m_oob);
    if (fb_we) begin
      dut_mem[int'(fb_adr_w)] = fb_d;
      wr_count++;
    end
    if (fill_done) done_count++;

    // model advance
    hit = 0;
    if (win >= 0) begin
      m_last = win;
      if (win < NR) begin
        a = req_adr[win*AW +: AW];
        d = req_data[win*DW +: DW];
      end else begin
        a = AW'((m_base + m_idx) % 65536);
        d = m_color;
        m_fill_wr++;
      end
      hit = int'(a) >= WORDS;
      m_we  = !(Bounds && hit);
      m_adr = a;
      m_d   = d;
    end else begin
      m_we = 0;
    end
    if (Bounds) m_oob = hit ? 1'b1 : (oob_clr ? 1'b0 : m_oob);
    m_done = (m_mode == 2);
    case (m_mode)
      0: if (fill_start) begin
        m_base = int'(fill_base); m_count = int'(fill_count); m_color = fill_color;
        m_idx = 0; m_mode = (m_count == 0) ? 2 : 1;
      end
      1: if (fill_abort) m_mode = 0;
         else if (win == NR) begin
           if (m_idx == m_count - 1) m_mode = 2;
           else m_idx++;
         end
      default: m_mode = 0;
    endcase

    @(posedge clk);
    #1;
    if (win >= 0 && win < NR) req_valid[win] = 1'b0;
    refill();
  endtask

  task automatic do_reset();
    req_valid = '0; fill_start = 0; fill_abort = 0; oob_clr = 0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_fb_we", fb_we, 0);
    check_eq("rst_fb_adr_w", fb_adr_w, 0);
    check_eq("rst_fb_d", fb_d, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_fill_busy", fill_busy, 0);
    check_eq("rst_fill_done", fill_done, 0);
    check_eq("rst_oob_err", oob_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic start_fill(input int base, input int count, input logic [DW-1:0] color);
    fill_base = AW'(base); fill_count = (AW+1)'(count); fill_color = color;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
  endtask

  initial begin
    int wr0, guard;
    do_reset();

    // 1: idle after reset
    repeat (10) step();

    // 2: single write from requester 1
    req_adr[AW +: AW] = 16'h0123; req_data[DW +: DW] = 24'hFF8000; req_valid[1] = 1'b1;
    repeat (4) step();
    check_eq("t2_mem", mem_rd(16'h0123), 24'hFF8000);

    // 3: full contention, rotation 0,1,F
    refill_pct = 100; adr_lo = 16'h1000; adr_span = 16'h0FFF;
    refill();
    done_count = 0;
    start_fill(0, 6, 24'h0000FF);
    repeat (30) step();
    refill_pct = 0;
    repeat (4) step();
    check_eq("t3_done_once", done_count, 1);
    for (int i = 0; i < 6; i++) check_eq("t3_mem", mem_rd(i), 24'h0000FF);

    // 4a: zero-length fill
    done_count = 0; wr0 = wr_count;
    start_fill(16'h0400, 0, 24'h123456);
    repeat (5) step();
    check_eq("t4_zero_done", done_count, 1);
    check_eq("t4_zero_nowr", wr_count - wr0, 0);

    // 4b: address wrap
    start_fill(16'hFFFE, 4, 24'hABCDEF);
    repeat (10) step();
    check_eq("t4_wrap_fffe", mem_rd(16'hFFFE), 24'hABCDEF);
    check_eq("t4_wrap_ffff", mem_rd(16'hFFFF), 24'hABCDEF);
    check_eq("t4_wrap_0000", mem_rd(0), 24'hABCDEF);
    check_eq("t4_wrap_0001", mem_rd(1), 24'hABCDEF);

    // 5: abort, with an ignored restart mid-fill
    dut_mem.delete(); done_count = 0; wr0 = wr_count; m_fill_wr = 0;
    start_fill(100, 1000, 24'h112233);
    guard = 0;
    while (wr_count - wr0 < 9 && guard < 200) begin
      if (guard == 4) begin
        fill_base = 16'd500; fill_count = 17'd3; fill_color = 24'h445566; fill_start = 1'b1;
      end
      step();
      fill_start = 1'b0;
      guard++;
    end
    check_eq("t5_reached_writes", guard < 200, 1);
    fill_abort = 1'b1;
    step();
    fill_abort = 1'b0;
    repeat (5) step();
    check_eq("t5_busy_low", fill_busy, 0);
    check_eq("t5_no_done", done_count, 0);
    check_eq("t5_wr_total", wr_count - wr0, m_fill_wr);
    check_eq("t5_wr_range", (wr_count - wr0 >= 10) && (wr_count - wr0 <= 11), 1);
    check_eq("t5_no_relatch", dut_mem.exists(500), 0);
    check_eq("t5_last_color", mem_rd(100), 24'h112233);

    // reset in the middle of a fill
    start_fill(16'h2000, 50, 24'h777777);
    repeat (5) step();
    do_reset();
    repeat (3) step();

    // 6: write just past the framebuffer
    req_adr[0 +: AW] = 16'(WORDS); req_data[0 +: DW] = 24'h5A5A5A; req_valid[0] = 1'b1;
    repeat (4) step();
    check_eq("t6_consumed", req_valid[0], 0);
    check_eq("t6_written", dut_mem.exists(WORDS), !Bounds);
    check_eq("t6_oob_sticky", oob_err, Bounds);
    oob_clr = 1'b1;
    step();
    oob_clr = 1'b0;
    step();
    check_eq("t6_oob_cleared", oob_err, 0);

    // random traffic
    refill_pct = 50; adr_lo = 0; adr_span = 65535;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 3) begin
        fill_start = 1'b1; fill_base = AW'($urandom);
        fill_count = (AW+1)'($urandom_range(20)); fill_color = DW'($urandom);
      end
      fill_abort = ($urandom_range(99) < 2);
      oob_clr    = ($urandom_range(99) < 5);
      step();
      fill_start = 1'b0; fill_abort = 1'b0; oob_clr = 1'b0;
    end
    refill_pct = 0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
